// File: rtl/load_store_unit_if.sv
// Bus bundle between the MEM stage, the load/store sequencer and the byte-wide data RAM.
// master = pipeline + RAM side, slave = the sequencer.
interface load_store_unit_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
        input  busy, done, err, rdata, ram_addr, ram_we, ram_wdata
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
        output busy, done, err, rdata, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Serialises one load/store into 1, 2 or 4 big-endian byte accesses on a synchronous
// single-port RAM, stalling the pipeline and returning the extended load word.
module load_store_unit #(
    parameter int ADDR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_DRAIN  = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              write_q, unsigned_q;
    logic [1:0]        size_q;
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [23:0]       shift_q;

    logic              accept;
    logic              misaligned;
    logic [1:0]        last_cnt;
    logic [1:0]        byte_sel;
    logic              in_access;
    logic              unused_addr_hi;

    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic [1:0]  size,
                                                input logic        zero_ext);
        logic [31:0] res;
        case (size)
            2'b00:   res = {{24{~zero_ext & raw[7]}}, raw[7:0]};
            2'b01:   res = {{16{~zero_ext & raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W];

    assign accept     = (state_q == S_IDLE) && bus.req_valid;
    assign misaligned = (bus.req_size == 2'b11)
                     || ((bus.req_size == 2'b01) && bus.req_addr[0])
                     || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    // last_cnt = N-1: 0 for byte, 1 for half, 3 for word
    assign last_cnt  = {size_q[1], size_q[1] | size_q[0]};
    assign byte_sel  = last_cnt - cnt_q;
    assign in_access = (state_q == S_ACCESS);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    cnt_d   = 2'd0;
                    state_d = misaligned ? S_ERR : S_ACCESS;
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == last_cnt) begin
                    cnt_d   = 2'd0;
                    state_d = write_q ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q    <= bus.req_write;
                size_q     <= bus.req_size;
                unsigned_q <= bus.req_unsigned;
            end
            // The last byte arrives during DRAIN; fold it in and publish for DONE
            if (state_q == S_DRAIN)
                rdata_q <= extend_load({shift_q, bus.ram_rdata}, size_q, unsigned_q);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= bus.req_addr[ADDR_W-1:0];
            wdata_q <= bus.req_wdata;
        end
        // RAM data lags the address by one cycle, so byte cnt-1 is on ram_rdata now
        if (in_access && !write_q && (cnt_q != 2'd0))
            shift_q <= {shift_q[15:0], bus.ram_rdata};
    end

    assign bus.busy      = in_access || (state_q == S_DRAIN);
    assign bus.done      = (state_q == S_DONE) || (state_q == S_ERR);
    assign bus.err       = (state_q == S_ERR);
    assign bus.rdata     = rdata_q;
    assign bus.ram_we    = in_access && write_q;
    assign bus.ram_wdata = bus.ram_we ? wdata_q[{byte_sel, 3'b000} +: 8] : 8'h00;
    assign bus.ram_addr  = in_access ? (addr_q + ADDR_W'(cnt_q)) : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// Randomised and directed checks of load_store_unit against a per-request timeline model.
module tb_load_store_unit;
    localparam int ADDR_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] ram [0:65535] = '{default: 8'h00};
    logic [7:0] mdl [0:65535] = '{default: 8'h00};

    always @(posedge clk) begin
        if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= ram[bus.ram_addr];
    end

    typedef struct {
        bit          busy;
        bit          done;
        bit          err;
        bit          we;
        bit          chk_addr;
        bit          upd;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [31:0] rd;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mdl_rdata = 32'd0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input int n, input bit u, input logic [15:0] a);
        longint      v;
        logic [15:0] p;
        v = 0;
        for (int i = 0; i < n; i++) begin
            p = a + 16'(i);
            v = v * 256 + longint'(mdl[p]);
        end
        if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    // Expected outputs for every cycle after acceptance, derived from size and direction
    task automatic push_req(input bit w, input logic [1:0] sz, input bit u,
                            input logic [31:0] ad, input logic [31:0] wd);
        exp_t e;
        int   n;
        bit   bad;
        bad = (sz == 2'b11) || (sz == 2'b01 && ad[0]) || (sz == 2'b10 && ad[1:0] != 2'b00);
        if (bad) begin
            e = '{default: 0};
            e.done = 1;
            e.err  = 1;
            q.push_back(e);
            return;
        end
        n = 1 << sz;
        for (int i = 0; i < n; i++) begin
            e = '{default: 0};
            e.busy     = 1;
            e.chk_addr = 1;
            e.addr     = ad[15:0] + 16'(i);
            if (w) begin
                e.we    = 1;
                e.wdata = 8'(wd >> (8 * (n - 1 - i)));
            end
            q.push_back(e);
        end
        if (!w) begin
            e = '{default: 0};
            e.busy = 1;
            q.push_back(e);
        end
        e = '{default: 0};
        e.done = 1;
        if (!w) begin
            e.upd = 1;
            e.rd  = model_load(n, u, ad[15:0]);
        end
        q.push_back(e);
    endtask

    task automatic step(input bit v, input bit w, input logic [1:0] sz, input bit u,
                        input logic [31:0] ad, input logic [31:0] wd);
        exp_t e;
        bit   was_idle;
        @(negedge clk);
        was_idle = (q.size() == 0);
        if (was_idle) e = '{default: 0};
        else          e = q.pop_front();
        if (e.upd) mdl_rdata = e.rd;
        chk("busy", 32'(bus.busy), 32'(e.busy));
        chk("done", 32'(bus.done), 32'(e.done));
        chk("err", 32'(bus.err), 32'(e.err));
        chk("ram_we", 32'(bus.ram_we), 32'(e.we));
        chk("ram_wdata", 32'(bus.ram_wdata), 32'(e.we ? e.wdata : 8'h00));
        chk("rdata", bus.rdata, mdl_rdata);
        if (e.chk_addr) chk("ram_addr", 32'(bus.ram_addr), 32'(e.addr));
        if (e.we) mdl[e.addr] = e.wdata;
        bus.req_valid    = v;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.req_addr     = ad;
        bus.req_wdata    = wd;
        if (was_idle && v) push_req(w, sz, u, ad, wd);
    endtask

    task automatic run(input bit w, input logic [1:0] sz, input bit u,
                       input logic [31:0] ad, input logic [31:0] wd,
                       output int lat, output int nwe);
        int c;
        step(1'b1, w, sz, u, ad, wd);
        lat = -1;
        nwe = 0;
        c   = 0;
        while (q.size() != 0 && c < 20) begin
            step(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
            c++;
            if (bus.ram_we) nwe++;
            if (bus.done && lat < 0) lat = c;
        end
    endtask

    initial begin
        int          lat, nwe, ndone;
        bit          w, u;
        logic [1:0]  sz;
        logic [31:0] ad;

        bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0;
        bus.req_unsigned = 0; bus.req_addr = 0; bus.req_wdata = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset rdata", bus.rdata, 32'd0);
        chk("reset ram_addr", 32'(bus.ram_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(1, 2'b10, 0, 32'h0000_0010, 32'hDEADBEEF, lat, nwe);
        chk("SW latency", lat, 5);
        chk("SW we cycles", nwe, 4);
        chk("RAM 0x10", 32'(ram[16'h10]), 32'hDE);
        chk("RAM 0x11", 32'(ram[16'h11]), 32'hAD);
        chk("RAM 0x12", 32'(ram[16'h12]), 32'hBE);
        chk("RAM 0x13", 32'(ram[16'h13]), 32'hEF);
        run(0, 2'b10, 0, 32'h0000_0010, 32'd0, lat, nwe);
        chk("LW latency", lat, 6);
        chk("LW rdata", bus.rdata, 32'hDEADBEEF);
        run(0, 2'b00, 0, 32'h0000_0011, 32'd0, lat, nwe);
        chk("LB latency", lat, 3);
        chk("LB rdata", bus.rdata, 32'hFFFFFFAD);
        run(0, 2'b00, 1, 32'h0000_0011, 32'd0, lat, nwe);
        chk("LBU rdata", bus.rdata, 32'h000000AD);
        run(0, 2'b01, 0, 32'h0000_0012, 32'd0, lat, nwe);
        chk("LH latency", lat, 4);
        chk("LH rdata", bus.rdata, 32'hFFFFBEEF);
        run(0, 2'b01, 1, 32'h0000_0012, 32'd0, lat, nwe);
        chk("LHU rdata", bus.rdata, 32'h0000BEEF);
        run(0, 2'b01, 0, 32'h0000_0010, 32'd0, lat, nwe);
        chk("LH 0x10 rdata", bus.rdata, 32'hFFFFDEAD);
        run(1, 2'b00, 0, 32'h0000_0013, 32'h12345677, lat, nwe);
        chk("SB latency", lat, 2);
        chk("SB we cycles", nwe, 1);
        run(0, 2'b10, 0, 32'h0000_0010, 32'd0, lat, nwe);
        chk("LW after SB", bus.rdata, 32'hDEADBE77);

        run(0, 2'b10, 0, 32'h0000_0012, 32'd0, lat, nwe);
        chk("LW misaligned latency", lat, 1);
        chk("LW misaligned we", nwe, 0);
        run(1, 2'b01, 0, 32'h0000_0011, 32'hFFFF_FFFF, lat, nwe);
        chk("SH misaligned latency", lat, 1);
        chk("SH misaligned we", nwe, 0);
        run(1, 2'b11, 0, 32'h0000_0010, 32'hFFFF_FFFF, lat, nwe);
        chk("size 11 latency", lat, 1);
        chk("size 11 we", nwe, 0);
        chk("err keeps rdata", bus.rdata, 32'hDEADBE77);

        // Reset lands in the third ACCESS cycle of a word store
        step(1, 1, 2'b10, 0, 32'h0000_0020, 32'hAABBCCDD);
        step(0, 0, 2'b00, 0, 32'd0, 32'd0);
        step(0, 0, 2'b00, 0, 32'd0, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid-reset busy", 32'(bus.busy), 32'd0);
        chk("mid-reset done", 32'(bus.done), 32'd0);
        chk("mid-reset err", 32'(bus.err), 32'd0);
        chk("mid-reset ram_we", 32'(bus.ram_we), 32'd0);
        chk("mid-reset ram_wdata", 32'(bus.ram_wdata), 32'd0);
        chk("mid-reset ram_addr", 32'(bus.ram_addr), 32'd0);
        chk("mid-reset rdata", bus.rdata, 32'd0);
        q.delete();
        mdl_rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("RAM 0x20", 32'(ram[16'h20]), 32'hAA);
        chk("RAM 0x21", 32'(ram[16'h21]), 32'hBB);
        chk("RAM 0x22", 32'(ram[16'h22]), 32'h00);
        chk("RAM 0x23", 32'(ram[16'h23]), 32'h00);
        run(0, 2'b10, 0, 32'h0000_0020, 32'd0, lat, nwe);
        chk("LW after reset latency", lat, 6);
        chk("LW after reset", bus.rdata, 32'hAABB0000);

        // req_valid held high: one access per IDLE edge, never queued
        ndone = 0;
        step(1, 0, 2'b00, 0, 32'h0000_0011, 32'd0);
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 2'b00, 0, 32'h0000_0011, 32'd0);
            if (bus.done) ndone++;
        end
        chk("held valid done count", ndone, 2);
        while (q.size() != 0) step(0, 0, 2'b00, 0, 32'd0, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            sz = (($urandom_range(0, 9)) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            ad = {$urandom, 16'h0000} | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) ad[15:6] = 10'h3FF;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) ad[0] = 1'b0;
                if (sz == 2'b10) ad[1:0] = 2'b00;
            end
            step(($urandom_range(0, 3) != 0), w, sz, u, ad, $urandom);
        end
        while (q.size() != 0) step(0, 0, 2'b00, 0, 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencer between the pipeline MEM stage and the byte-wide data RAM. It accepts one load or store per request (byte, halfword or word, signed or unsigned) and serialises it into 1, 2 or 4 big-endian byte accesses on a single synchronous RAM port. It stalls the pipeline while the access runs, then returns the assembled, sign- or zero-extended load word.

## Interface
- ADDR_W, 16, RAM byte-address width.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present from MEM stage.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address; only [ADDR_W-1:0] used.
- req_wdata  in  32  store data, right-aligned.
- busy  out  1  stall: high in ACCESS and DRAIN.
- done  out  1  one-cycle completion pulse.
- err  out  1  misalignment/illegal-size pulse, coincident with done.
- rdata  out  32  load result, valid with done, held until the next load's done.
- ram_addr  out  ADDR_W  byte address to RAM.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  8  RAM write byte.
- ram_rdata  in  8  RAM read byte; the RAM registers the address and returns data one cycle later.

## Operation
- States: IDLE, ACCESS, DRAIN, DONE, ERR.
- IDLE: on a clock edge with req_valid=1, latch all req_* and set N = 1/2/4 by size.
  - If size is 11, or a half has addr[0]=1, or a word has addr[1:0]≠0: go to ERR.
  - Otherwise go to ACCESS with cnt=0.
- ACCESS: ram_addr = latched addr + cnt, modulo 2^ADDR_W.
  - Store: ram_we=1. ram_wdata = byte (N-1-cnt) of wdata, so the MSB goes to the lowest address.
  - Load: ram_we=0. From cnt≥1, capture ram_rdata as byte cnt-1.
  - Increment cnt each cycle.
  - At cnt=N-1: store goes to DONE; load goes to DRAIN.
- DRAIN: capture the final byte (N-1). Go to DONE.
- DONE: done=1 for one cycle. A load updates rdata this cycle. Go to IDLE.
- ERR: done=1 and err=1 for one cycle. No RAM access occurs and rdata is unchanged. Go to IDLE.
- Load assembly (big-endian):
  - byte: {24 ext, b0}.
  - half: {16 ext, b0, b1}.
  - word: {b0, b1, b2, b3}.
  - ext is the copy of the MSB of b0 when req_unsigned=0, otherwise zero.
- Requests are accepted only in IDLE. req_valid in any other state, including DONE, is ignored and not queued.
- ram_wdata = 0 and ram_we = 0 whenever not storing in ACCESS.
- Unused state encodings recover to IDLE.

## Timing
- Reset values (asynchronous on rst_n=0):
  - state IDLE, cnt=0.
  - busy, done, err, ram_we = 0.
  - rdata, ram_addr, ram_wdata = 0.
- Cycle numbering: the acceptance edge ends cycle 0.
- Stores: ACCESS in cycles 1..N, done in cycle N+1.
  - SB: done at cycle 2. SH: cycle 3. SW: cycle 5.
- Loads: ACCESS in cycles 1..N, DRAIN in cycle N+1, done in cycle N+2.
  - LB: done at cycle 3. LH: cycle 4. LW: cycle 6.
- Errors: done and err at cycle 1.
- busy is high in cycles 1 through the last ACCESS/DRAIN cycle and low in DONE. The pipeline advances on done.
- Reset during ACCESS: ram_we drops immediately. Bytes already written stay written; the rest are not written. No done is produced.

## Test plan
- SW 0xDEADBEEF at 0x0010:
  - RAM[0x10..0x13] = DE, AD, BE, EF.
  - ram_we high cycles 1–4, done at cycle 5.
  - Then LW 0x0010 gives rdata = 0xDEADBEEF with done at cycle 6.
- Sign and zero extension, with the word above in RAM:
  - LB 0x0011 → 0xFFFFFFAD; LBU 0x0011 → 0x000000AD.
  - LH 0x0012 → 0xFFFFBEEF; LHU 0x0012 → 0x0000BEEF.
  - LH 0x0010 signed → 0xFFFFDEAD.
- SB 0x0013 with wdata 0x12345677:
  - A single ram_we cycle writing 0x77 at 0x13.
  - LW 0x0010 → 0xDEADBE77.
- Errors:
  - LW 0x0012, SH 0x0011 and size=11 each give done+err at cycle 1.
  - ram_we stays 0 and rdata keeps its previous value.
- Reset mid-store: rst_n low during cycle 3 of SW 0xAABBCCDD at 0x0020.
  - All outputs are 0 immediately.
  - RAM[0x20..0x21] = AA, BB; RAM[0x22..0x23] unchanged.
  - The first request after reset completes normally.
- Request handling:
  - req_valid held high through busy and DONE gives exactly one access.
  - The next request is accepted on the first IDLE edge, with done separated by the full latency.
